// File: rtl/shift_pkg.sv
// Shared types for the shift sequencer.
//   shift_op_e  : shift operation encoding carried on req_op
//   seq_state_e : sequencer FSM states
package shift_pkg;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASL = 2'b10,
    ASR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational one-bit shifter: applies a single step of the selected
// operation and reports the bit that fell off the end.
// Ports:
//   data_in   in  WIDTH  operand
//   op        in  2      shift_op_e operation
//   data_out  out WIDTH  operand shifted by one position
//   carry_out out 1      bit shifted out
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_in,
  input  shift_op_e        op,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out
);

  always_comb begin
    data_out  = {data_in[WIDTH-2:0], 1'b0};
    carry_out = data_in[WIDTH-1];
    case (op)
      LSL, ASL: begin
        // Arithmetic left shift is bit-identical to logical left shift.
        data_out  = {data_in[WIDTH-2:0], 1'b0};
        carry_out = data_in[WIDTH-1];
      end
      LSR: begin
        data_out  = {1'b0, data_in[WIDTH-1:1]};
        carry_out = data_in[0];
      end
      ASR: begin
        // Sign bit is replicated into the vacated MSB.
        data_out  = {data_in[WIDTH-1], data_in[WIDTH-1:1]};
        carry_out = data_in[0];
      end
      default: begin
        data_out  = {data_in[WIDTH-2:0], 1'b0};
        carry_out = data_in[WIDTH-1];
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller. Accepts (data, op, amount) on a valid/ready
// request port, applies one single-bit shift step per clock `amount` times,
// then presents the result and the last bit shifted out on a valid/ready
// response port.
// Ports:
//   clk        in  1      clock, rising edge
//   rst_n      in  1      synchronous active-low reset
//   flush      in  1      synchronous abort of any in-flight/undelivered op
//   req_valid  in  1      request present
//   req_ready  out 1      high in IDLE
//   req_data   in  WIDTH  operand
//   req_op     in  2      00 LSL, 01 LSR, 10 ASL, 11 ASR
//   req_amt    in  AMT_W  number of one-bit steps (not clamped)
//   rsp_valid  out 1      result present (DONE)
//   rsp_ready  in  1      consumer takes result
//   rsp_data   out WIDTH  shifted result
//   rsp_carry  out 1      last bit shifted out (0 when amount is 0)
//   busy       out 1      state != IDLE
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [1:0]       req_op,
  input  logic [AMT_W-1:0] req_amt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             busy
);

  localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  shift_op_e        op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data_in   (acc_q),
    .op        (op_q),
    .data_out  (step_data),
    .carry_out (step_carry)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;

    // Flush wins over everything in the FSM, including a request offered
    // in the same cycle, so the datapath registers are left untouched.
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            acc_d   = req_data;
            op_d    = shift_op_e'(req_op);
            cnt_d   = req_amt;
            carry_d = 1'b0;
            state_d = (req_amt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          acc_d   = step_data;
          carry_d = step_carry;
          cnt_d   = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      op_q    <= LSL;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  // All outputs come from registers only. Result fields are masked outside
  // DONE so a stale or aborted accumulator never leaks onto the port.
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = (state_q == DONE) ? acc_q : '0;
  assign rsp_carry = (state_q == DONE) ? carry_q : 1'b0;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic [1:0] req_op;
  logic [3:0] req_amt;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(8), .AMT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_op    (req_op),
    .req_amt   (req_amt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .busy      (busy)
  );

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [7:0] data;
    logic [3:0] amt;
    logic [7:0] exp_data;
    logic       exp_carry;
    int         hold;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: whole-operation result from arithmetic on the operand,
  // independent of any step-by-step iteration. Returns {carry, data}.
  function automatic logic [8:0] model(input logic [1:0] op, input logic [7:0] d, input int amt);
    logic [15:0]       ext;
    logic [15:0]       t;
    logic [7:0]        r;
    logic signed [7:0] s;
    logic              c;
    c = 1'b0;
    case (op)
      2'b01: begin
        r   = d >> amt;
        ext = {8'h00, d};
        t   = ext >> (amt - 1);
        if (amt != 0) c = t[0];
      end
      2'b11: begin
        s   = d;
        r   = s >>> amt;
        ext = {{8{d[7]}}, d};
        t   = ext >> (amt - 1);
        if (amt != 0) c = t[0];
      end
      default: begin
        r   = d << amt;
        ext = {8'h00, d};
        t   = ext << (amt - 1);
        if (amt != 0) c = t[7];
      end
    endcase
    return {c, r};
  endfunction

  task automatic run_txn(input string name, input logic [1:0] op, input logic [7:0] data,
                         input logic [3:0] amt, input logic [7:0] exp_d, input logic exp_c,
                         input int hold, input bit junk);
    int         w;
    int         lat;
    logic [7:0] got_d;
    logic       got_c;
    w = 0;
    while (!req_ready && w < 20) begin
      tick();
      w++;
    end
    check({name, " req_ready_idle"}, req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    req_amt   = amt;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      if (junk) begin
        req_valid = 1'($urandom_range(0, 1));
        req_data  = 8'($urandom);
        req_op    = 2'($urandom);
        req_amt   = 4'($urandom);
      end
      tick();
      lat++;
    end
    got_d = rsp_data;
    got_c = rsp_carry;
    check({name, " rsp_valid"}, rsp_valid, 1);
    check({name, " latency"}, lat, amt + 1);
    check({name, " rsp_data"}, got_d, exp_d);
    check({name, " rsp_carry"}, got_c, exp_c);
    for (int h = 0; h < hold; h++) begin
      if (junk) begin
        req_valid = 1'b1;
        req_data  = 8'($urandom);
        req_amt   = 4'($urandom);
      end
      tick();
      check({name, " hold_valid"}, rsp_valid, 1);
      check({name, " hold_data"}, rsp_data, exp_d);
      check({name, " hold_carry"}, rsp_carry, exp_c);
      check({name, " hold_req_ready"}, req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({name, " post_valid"}, rsp_valid, 0);
    check({name, " post_req_ready"}, req_ready, 1);
    check({name, " post_busy"}, busy, 0);
    $display("txn %s op=%0d data=%02h amt=%0d -> data=%02h carry=%0b lat=%0d",
             name, op, data, amt, got_d, got_c, lat);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " rsp_valid"}, rsp_valid, 0);
    check({name, " rsp_data"}, rsp_data, 0);
    check({name, " rsp_carry"}, rsp_carry, 0);
    check({name, " busy"}, busy, 0);
    check({name, " req_ready"}, req_ready, 1);
  endtask

  initial begin
    logic [8:0] m;
    logic [1:0] r_op;
    logic [7:0] r_data;
    logic [3:0] r_amt;
    bit         seen;

    vecs[0] = '{"lsl81_3",   2'b00, 8'h81, 4'd3,  8'h08, 1'b0, 0};
    vecs[1] = '{"asr90_2",   2'b11, 8'h90, 4'd2,  8'hE4, 1'b0, 0};
    vecs[2] = '{"lsr90_2",   2'b01, 8'h90, 4'd2,  8'h24, 1'b0, 0};
    vecs[3] = '{"amt0_lsl",  2'b00, 8'h5A, 4'd0,  8'h5A, 1'b0, 0};
    vecs[4] = '{"amt0_lsr",  2'b01, 8'h5A, 4'd0,  8'h5A, 1'b0, 0};
    vecs[5] = '{"amt0_asl",  2'b10, 8'h5A, 4'd0,  8'h5A, 1'b0, 0};
    vecs[6] = '{"amt0_asr",  2'b11, 8'h5A, 4'd0,  8'h5A, 1'b0, 0};
    vecs[7] = '{"aslC1_9",   2'b10, 8'hC1, 4'd9,  8'h00, 1'b0, 0};
    vecs[8] = '{"asr80_15",  2'b11, 8'h80, 4'd15, 8'hFF, 1'b1, 0};
    vecs[9] = '{"backpress", 2'b00, 8'h81, 4'd3,  8'h08, 1'b0, 5};

    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_data  = '0;
    req_op    = '0;
    req_amt   = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].name, vecs[i].op, vecs[i].data, vecs[i].amt,
              vecs[i].exp_data, vecs[i].exp_carry, vecs[i].hold, vecs[i].hold != 0);
    end

    for (int i = 0; i < 40; i++) begin
      r_op   = 2'($urandom);
      r_data = 8'($urandom);
      r_amt  = 4'($urandom_range(0, 15));
      m      = model(r_op, r_data, int'(r_amt));
      run_txn("rand", r_op, r_data, r_amt, m[7:0], m[8], $urandom_range(0, 3), 1'b1);
    end

    // Flush during the second SHIFT cycle of a 6-step operation.
    req_valid = 1'b1; req_op = 2'b00; req_data = 8'hA5; req_amt = 4'd6;
    tick();
    req_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", busy, 0);
    check("flush req_ready", req_ready, 1);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid || busy) seen = 1'b1;
    end
    check("flush no_rsp", seen, 0);
    $display("txn flush_mid_shift busy=%0b rsp_seen=%0b", busy, seen);

    // Flush in IDLE with a request offered: request must not be taken.
    req_valid = 1'b1; req_op = 2'b01; req_data = 8'h3C; req_amt = 4'd0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    check("flush_idle busy", busy, 0);
    check("flush_idle rsp_valid", rsp_valid, 0);
    $display("txn flush_with_request busy=%0b", busy);

    run_txn("after_flush", 2'b01, 8'h90, 4'd2, 8'h24, 1'b0, 0, 1'b0);

    // Reset in the middle of a 6-step operation.
    req_valid = 1'b1; req_op = 2'b11; req_data = 8'h80; req_amt = 4'd6;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("rst_mid_shift");
    rst_n = 1'b1;
    tick();
    check_reset_outputs("rst_mid_shift_after");
    $display("txn reset_mid_shift busy=%0b", busy);

    // Reset while a result is waiting in DONE.
    req_valid = 1'b1; req_op = 2'b00; req_data = 8'h5A; req_amt = 4'd0;
    tick();
    req_valid = 1'b0;
    check("rst_done pre_valid", rsp_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_outputs("rst_in_done");
    $display("txn reset_in_done rsp_valid=%0b", rsp_valid);

    run_txn("after_reset", 2'b11, 8'h90, 4'd2, 8'hE4, 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
